// File: rtl/inst_encoder.sv
// Packs field-level instruction descriptions into MIPS words and writes them to instruction RAM.
// Optional macro ENC_BRANCH_REL_EN enables kind 5 (PC-relative branch from absolute target).
module inst_encoder #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [31:0]      load_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_kind,
    input  logic [5:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [5:0]       in_funct,
    input  logic [31:0]      in_imm,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err
);

    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    typedef enum logic {S_IDLE, S_LI2} state_t;

    state_t      state_q, state_d;
    logic [31:0] ptr;
    logic [31:0] ptr4;
    logic [15:0] li_lo;
    logic [4:0]  li_rt;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        enc_two;
    logic        imm_s16;
    logic        accept;
    logic        unused_ok;

    assign unused_ok = ^load_addr[1:0];
    assign in_ready  = (state_q == S_IDLE) && !load_en;
    assign accept    = in_valid && in_ready;
    assign ptr4      = ptr + 32'd4;
    assign imm_s16   = (&in_imm[31:15]) || !(|in_imm[31:15]);

`ifdef ENC_BRANCH_REL_EN
    logic [31:0] br_diff;
    logic [31:0] br_off;
    logic        br_fits;
    assign br_diff = in_imm - ptr4;
    assign br_off  = 32'($signed(br_diff) >>> 2);
    assign br_fits = (&br_off[31:15]) || !(|br_off[31:15]);
`endif

    // Field packing and range checks for the description presented this cycle
    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        enc_two  = 1'b0;
        case (in_kind)
            3'd0: enc_word = {6'b0, in_rs, in_rt, in_rd, in_shamt, in_funct};
            3'd1: begin
                enc_word = {in_op, in_rs, in_rt, in_imm[15:0]};
                enc_err  = !imm_s16;
            end
            3'd2: begin
                enc_word = {in_op, in_rs, in_rt, in_imm[15:0]};
                enc_err  = |in_imm[31:16];
            end
            3'd3: begin
                enc_word = {in_op, in_imm[27:2]};
                enc_err  = (|in_imm[1:0]) || (in_imm[31:28] != ptr4[31:28]);
            end
            3'd4: begin
                if (imm_s16) begin
                    enc_word = {OP_ADDIU, 5'd0, in_rt, in_imm[15:0]};
                end else begin
                    enc_word = {OP_LUI, 5'd0, in_rt, in_imm[31:16]};
                    enc_two  = |in_imm[15:0];
                end
            end
`ifdef ENC_BRANCH_REL_EN
            3'd5: begin
                enc_word = {in_op, in_rs, in_rt, br_off[15:0]};
                enc_err  = (|in_imm[1:0]) || !br_fits;
            end
`endif
            default: enc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !enc_err && enc_two) state_d = S_LI2;
            S_LI2:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write port, pointer, counter and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= RESET_ADDR;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            word_cnt  <= '0;
            err       <= 1'b0;
            li_lo     <= '0;
            li_rt     <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state_q == S_LI2) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr;
                mem_wdata <= {OP_ORI, li_rt, li_rt, li_lo};
                ptr       <= ptr4;
                word_cnt  <= word_cnt + CNT_W'(1);
            end else if (load_en) begin
                ptr <= {load_addr[31:2], 2'b00};
                err <= 1'b0;
            end else if (in_valid) begin
                if (enc_err) begin
                    err <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= enc_word;
                    ptr       <= ptr4;
                    word_cnt  <= word_cnt + CNT_W'(1);
                    li_lo     <= in_imm[15:0];
                    li_rt     <= in_rt;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder; define ENC_BRANCH_REL_EN to exercise branches.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [31:0] load_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [5:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [31:0] in_imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] word_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;

    inst_encoder dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_cnt(word_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a description at a falling edge; return at the next falling edge (cycle N+1 visible)
    task automatic send(input logic [2:0] kind, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [31:0] imm);
        @(negedge clk);
        in_kind = kind; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_funct = fn; in_imm = imm; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr);
        @(negedge clk);
        load_en = 1'b1; load_addr = addr;
        #1 chk("ready_low_during_load", 32'(in_ready), 32'd0);
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [15:0] c);
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_data"}, mem_wdata, d);
        chk({tag, "_cnt"}, 32'(word_cnt), 32'(c));
    endtask

    task automatic chk_err(input string tag, input logic [15:0] c);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_cnt"}, 32'(word_cnt), 32'(c));
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; in_valid = 1'b0;
        in_kind = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_shamt = '0; in_funct = '0; in_imm = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_data", mem_wdata, 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        do_load(32'h0040_0000);
        send(3'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'd0);
        chk_write("r_add", 32'h0040_0000, 32'h0022_1820, 16'd1);
        @(negedge clk);
        chk("r_we_one_cycle", 32'(mem_we), 32'd0);

        // Two-word LI: lui then ori back to back, ready low during the second
        send(3'd4, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678);
        chk_write("li2_hi", 32'h0040_0004, 32'h3C08_1234, 16'd2);
        chk("li2_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk_write("li2_lo", 32'h0040_0008, 32'h3508_5678, 16'd3);
        chk("li2_ready_back", 32'(in_ready), 32'd1);

        send(3'd4, 6'd0, 5'd0, 5'd9, 5'd0, 5'd0, 6'd0, 32'hFFFF_FFFB);
        chk_write("li_addiu", 32'h0040_000C, 32'h2409_FFFB, 16'd4);
        chk("li_addiu_ready", 32'(in_ready), 32'd1);
        send(3'd4, 6'd0, 5'd0, 5'd9, 5'd0, 5'd0, 6'd0, 32'h0005_0000);
        chk_write("li_lui", 32'h0040_0010, 32'h3C09_0005, 16'd5);
        chk("li_lui_ready", 32'(in_ready), 32'd1);

        // Signed immediate out of range, then normal encoding resumes at the same address
        send(3'd1, 6'h08, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 32'h0001_8000);
        chk_err("addi_range", 16'd5);
        send(3'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'd0);
        chk_write("r_after_err", 32'h0040_0014, 32'h0022_1820, 16'd6);
        chk("err_sticky", 32'(err), 32'd1);
        send(3'd2, 6'h0D, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0000_FFFF);
        chk_write("ori_uimm", 32'h0040_0018, 32'h3422_FFFF, 16'd7);
        send(3'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'hFFFF_8000);
        chk_write("addi_neg_edge", 32'h0040_001C, 32'h2022_8000, 16'd8);

        // load_en clears err; low address bits dropped
        do_load(32'h0040_0003);
        chk("load_clears_err", 32'(err), 32'd0);
        send(3'd2, 6'h0D, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0001_0000);
        chk_err("uimm_range", 16'd8);

        do_load(32'h0040_0000);
        send(3'd3, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0040_0010);
        chk_write("j_ok", 32'h0040_0000, 32'h0810_0004, 16'd9);
        send(3'd3, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0040_0012);
        chk_err("j_misaligned", 16'd9);
        do_load(32'h0040_0004);
        send(3'd3, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h1040_0010);
        chk_err("j_region", 16'd9);

        do_load(32'h0040_0000);
`ifdef ENC_BRANCH_REL_EN
        send(3'd5, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0040_0008);
        chk_write("beq_ok", 32'h0040_0000, 32'h1022_0001, 16'd10);
        chk("beq_no_err", 32'(err), 32'd0);
        send(3'd5, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0042_0008);
        chk_err("beq_range", 16'd10);
        do_load(32'h0040_0000);
        send(3'd3, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0040_0010);
        chk_write("j_after_br", 32'h0040_0000, 32'h0810_0004, 16'd11);
`else
        send(3'd5, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0040_0008);
        chk_err("kind5_invalid", 16'd9);
        do_load(32'h0040_0000);
        send(3'd3, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0040_0010);
        chk_write("j_after_br", 32'h0040_0000, 32'h0810_0004, 16'd10);
`endif
        send(3'd7, 6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 32'h0);
        chk("kind7_we", 32'(mem_we), 32'd0);
        chk("kind7_err", 32'(err), 32'd1);

        // Reset during LI2 drops the ori word and restarts at RESET_ADDR
        do_load(32'h0040_0100);
        send(3'd4, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 32'h1234_5678);
        chk("mid_li_hi_addr", mem_addr, 32'h0040_0100);
        reset = 1'b1;
        #1;
        chk("mid_li_rst_we", 32'(mem_we), 32'd0);
        chk("mid_li_rst_cnt", 32'(word_cnt), 32'd0);
        chk("mid_li_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_li_no_ori", 32'(mem_we), 32'd0);
        send(3'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'd0);
        chk_write("r_after_rst", 32'h0000_0000, 32'h0022_1820, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
